// File: rtl/rgmii_tx_framer_if.sv
// Byte-stream handshake into the RGMII transmit framer.
// Master drives data/markers; slave returns in_ready.
interface rgmii_tx_framer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_sop;
    logic       in_eop;
    logic       in_ready;

    modport master (
        output in_data, in_valid, in_sop, in_eop,
        input  in_ready
    );

    modport slave (
        input  in_data, in_valid, in_sop, in_eop,
        output in_ready
    );
endinterface

// File: rtl/rgmii_tx_framer.sv
// 100M RGMII transmit framer: preamble, SFD, payload, FCS, IFG.
// `define TX_FCS_EN to append a generated CRC-32 FCS.
module rgmii_tx_framer #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_BYTES      = 12
) (
    input  logic             rgmii_clk,
    input  logic             rst_n,
    input  logic             giga_mode,
    rgmii_tx_framer_if.slave s,
    output logic             rgmii_tx_ctrl,
    output logic             rgmii_tx_err,
    output logic [3:0]       rgmii_tx_data,
    output logic             tx_sop,
    output logic             tx_underrun,
    output logic [15:0]      frame_cnt
);
    localparam int PRE_N = 2 * PREAMBLE_BYTES;
    localparam int IFG_N = 2 * IFG_BYTES;
    localparam int FCS_N = 8;
    localparam int MAX_A = (PRE_N > IFG_N) ? PRE_N : IFG_N;
    localparam int MAX_N = (MAX_A > FCS_N) ? MAX_A : FCS_N;
    localparam int CW    = $clog2(MAX_N);

    localparam logic [CW-1:0] PRE_LAST = CW'(PRE_N - 1);
    localparam logic [CW-1:0] IFG_LAST = CW'(IFG_N - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        PAY_LO,
        PAY_HI,
        ABORT,
`ifdef TX_FCS_EN
        FCS,
`endif
        IFG
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    byte_q;
    logic          eop_q;
    logic          first_q;
    logic          run_q;
    logic          start;
    logic          load;
    logic          done;

`ifdef TX_FCS_EN
    localparam logic [CW-1:0] FCS_LAST = CW'(FCS_N - 1);

    logic [31:0] crc_q;
    logic [31:0] fcs;

    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign fcs  = ~crc_q;
    assign done = (state_q == FCS) && (cnt_q == FCS_LAST);
`else
    assign done = (state_q == PAY_HI) && eop_q;
`endif

    // run_q keeps the block deaf for the first cycle out of reset
    assign start = run_q & ~giga_mode & s.in_valid & s.in_sop;
    assign load  = s.in_valid & s.in_ready & (state_q != IDLE);

    always_ff @(posedge rgmii_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge rgmii_clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q    <= '0;
            eop_q     <= 1'b0;
            first_q   <= 1'b0;
            run_q     <= 1'b0;
            frame_cnt <= '0;
`ifdef TX_FCS_EN
            crc_q     <= '0;
`endif
        end else begin
            run_q <= 1'b1;
            if (load) begin
                byte_q <= s.in_data;
                eop_q  <= s.in_eop;
`ifdef TX_FCS_EN
                crc_q  <= crc_byte((state_q == SFD) ? 32'hFFFFFFFF : crc_q,
                                   s.in_data);
`endif
            end
            if (state_q == SFD)
                first_q <= 1'b1;
            else if (state_q == PAY_LO)
                first_q <= 1'b0;
            if (done)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PRE;
                    cnt_d   = '0;
                end
            end
            PRE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = SFD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            SFD: begin
                if (cnt_q[0]) begin
                    state_d = s.in_valid ? PAY_LO : ABORT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = ONE;
                end
            end
            PAY_LO: state_d = PAY_HI;
            PAY_HI: begin
                cnt_d = '0;
                if (eop_q)
`ifdef TX_FCS_EN
                    state_d = FCS;
`else
                    state_d = IFG;
`endif
                else if (s.in_valid)
                    state_d = PAY_LO;
                else
                    state_d = ABORT;
            end
            ABORT: begin
                if (cnt_q[0]) begin
                    state_d = IFG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = ONE;
                end
            end
`ifdef TX_FCS_EN
            FCS: begin
                if (cnt_q == FCS_LAST) begin
                    state_d = IFG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
`endif
            // a waiting SOP launches straight off the last gap cycle
            IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = start ? PRE : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        rgmii_tx_ctrl = 1'b0;
        rgmii_tx_err  = 1'b0;
        rgmii_tx_data = 4'h0;
        tx_sop        = 1'b0;
        tx_underrun   = 1'b0;
        s.in_ready    = 1'b0;
        unique case (state_q)
            IDLE: begin
                s.in_ready = run_q & ~giga_mode & s.in_valid & ~s.in_sop;
            end
            PRE: begin
                rgmii_tx_ctrl = 1'b1;
                rgmii_tx_data = 4'h5;
            end
            SFD: begin
                rgmii_tx_ctrl = 1'b1;
                rgmii_tx_data = cnt_q[0] ? 4'hD : 4'h5;
                s.in_ready    = cnt_q[0];
            end
            PAY_LO: begin
                rgmii_tx_ctrl = 1'b1;
                rgmii_tx_data = byte_q[3:0];
                tx_sop        = first_q;
            end
            PAY_HI: begin
                rgmii_tx_ctrl = 1'b1;
                rgmii_tx_data = byte_q[7:4];
                s.in_ready    = ~eop_q;
            end
            ABORT: begin
                rgmii_tx_ctrl = 1'b1;
                rgmii_tx_err  = 1'b1;
                tx_underrun   = ~cnt_q[0];
            end
`ifdef TX_FCS_EN
            FCS: begin
                rgmii_tx_ctrl = 1'b1;
                rgmii_tx_data = fcs[{cnt_q[2:0], 2'b00} +: 4];
            end
`endif
            IFG: ;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_rgmii_tx_framer.sv
// Directed bench for rgmii_tx_framer: framing, IFG timing, underrun,
// stray bytes, giga_mode hold-off and reset mid-frame.
module tb_rgmii_tx_framer;
`ifdef TX_FCS_EN
    localparam int FCSN = 8;
`else
    localparam int FCSN = 0;
`endif

    logic        rgmii_clk = 1'b0;
    logic        rst_n     = 1'b0;
    logic        giga_mode = 1'b0;
    logic        ctrl, err, und, sop;
    logic [3:0]  data;
    logic [15:0] fcnt;

    rgmii_tx_framer_if bus();

    rgmii_tx_framer dut (
        .rgmii_clk     (rgmii_clk),
        .rst_n         (rst_n),
        .giga_mode     (giga_mode),
        .s             (bus),
        .rgmii_tx_ctrl (ctrl),
        .rgmii_tx_err  (err),
        .rgmii_tx_data (data),
        .tx_sop        (sop),
        .tx_underrun   (und),
        .frame_cnt     (fcnt)
    );

    always #20 rgmii_clk = ~rgmii_clk;

    logic [7:0] b  [64];
    bit         sf [64];
    bit         ef [64];
    logic [3:0] nib[$];
    logic [3:0] ex[$];
    int rise[$], fall[$], acc[$], errc[$], undc[$], sopc[$], sopn[$];
    int cyc = 0;
    int pres0;
    int tests = 0;
    int fails = 0;
    bit prev_ctrl;

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic put(input int at, input int n, input int v0,
                       input bit framed);
        for (int i = 0; i < n; i++) begin
            b[at+i]  = 8'(v0 + i);
            sf[at+i] = framed && (i == 0);
            ef[at+i] = framed && (i == n - 1);
        end
    endtask

    task automatic idle_bus();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
    endtask

    // expected preamble + SFD + n payload bytes, low nibble first
    task automatic exp_frame(input int at, input int n);
        ex.delete();
        for (int i = 0; i < 14; i++) ex.push_back(4'h5);
        ex.push_back(4'h5);
        ex.push_back(4'hD);
        for (int i = 0; i < n; i++) begin
            ex.push_back(b[at+i][3:0]);
            ex.push_back(b[at+i][7:4]);
        end
    endtask

    function automatic int nib_bad();
        int bad = 0;
        for (int i = 0; i < ex.size(); i++)
            if (i >= nib.size() || nib[i] !== ex[i]) bad++;
        return bad;
    endfunction

    // Source model: plays b[0..nb-1], drops valid at index drop and
    // then jumps to resume once the framer shows it has underrun.
    task automatic run(input int nb, input int drop, input int resume,
                       input int budget, input int giga_until);
        int idx = 0;
        nib.delete(); rise.delete(); fall.delete(); acc.delete();
        errc.delete(); undc.delete(); sopc.delete(); sopn.delete();
        prev_ctrl = 1'b0;
        pres0 = -1;
        for (int c = 0; c < budget; c++) begin
            giga_mode = (c < giga_until);
            if (idx < nb && idx != drop) begin
                bus.in_valid = 1'b1;
                bus.in_data  = b[idx];
                bus.in_sop   = sf[idx];
                bus.in_eop   = ef[idx];
            end else begin
                idle_bus();
            end
            if (pres0 < 0 && bus.in_valid && bus.in_sop) pres0 = cyc;
            #1;
            if (ctrl) nib.push_back(data);
            if (ctrl && !prev_ctrl) rise.push_back(cyc);
            if (!ctrl && prev_ctrl) fall.push_back(cyc - 1);
            prev_ctrl = ctrl;
            if (err) errc.push_back(cyc);
            if (und) undc.push_back(cyc);
            if (sop) begin
                sopc.push_back(cyc);
                sopn.push_back(nib.size() - 1);
            end
            if (bus.in_valid && bus.in_ready) begin
                acc.push_back(cyc);
                idx++;
            end else if (idx == drop && bus.in_ready) begin
                idx = resume;
            end
            @(negedge rgmii_clk);
            cyc++;
        end
        idle_bus();
    endtask

    task automatic exp_123();
        exp_frame(0, 9);
`ifdef TX_FCS_EN
        ex.push_back(4'h6); ex.push_back(4'h2);
        ex.push_back(4'h9); ex.push_back(4'h3);
        ex.push_back(4'h4); ex.push_back(4'hF);
        ex.push_back(4'hB); ex.push_back(4'hC);
`endif
    endtask

    initial begin
        int n;
        idle_bus();
        repeat (3) @(negedge rgmii_clk);
        #1;
        chk("rst_ctrl", ctrl, 0);
        chk("rst_err", err, 0);
        chk("rst_data", data, 0);
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_sop", sop, 0);
        chk("rst_und", und, 0);
        chk("rst_cnt", fcnt, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge rgmii_clk);

        // single "123456789" frame
        put(0, 9, 'h31, 1'b1);
        run(9, -1, 0, 80, 0);
        exp_123();
        chk("t1_len", nib.size(), ex.size());
        chk("t1_nibs", nib_bad(), 0);
        chk("t1_rise", rise[0], pres0 + 1);
        chk("t1_sop_cnt", sopc.size(), 1);
        chk("t1_sop_nib", sopn[0], 16);
        chk("t1_cnt", fcnt, 1);
        chk("t1_acc", acc.size(), 9);
        chk("t1_err", errc.size(), 0);

        // back-to-back 4-byte frames
        put(0, 4, 'hA0, 1'b1);
        put(4, 4, 'hB0, 1'b1);
        run(8, -1, 0, 130, 0);
        exp_frame(0, 4);
        chk("t2_nibs", nib_bad(), 0);
        chk("t2_rises", rise.size(), 2);
        chk("t2_lat", rise[0], pres0 + 1);
        chk("t2_len", fall[0] - rise[0] + 1, 24 + FCSN);
        chk("t2_gap", rise[1] - fall[0], 25);
        chk("t2_acc", acc.size(), 8);
        n = 0;
        foreach (acc[i]) if (acc[i] < rise[1]) n++;
        chk("t2_acc1", n, 4);
        chk("t2_cnt", fcnt, 3);

        // underrun before byte 2 of 10, then a 4-byte frame waits
        put(0, 10, 'h10, 1'b1);
        put(10, 4, 'hC0, 1'b1);
        run(14, 2, 10, 130, 0);
        exp_frame(0, 2);
        ex.push_back(4'h0);
        ex.push_back(4'h0);
        chk("t3_len", fall[0] - rise[0] + 1, 22);
        chk("t3_nibs", nib_bad(), 0);
        chk("t3_errs", errc.size(), 2);
        chk("t3_err0", errc[0], fall[0] - 1);
        chk("t3_err1", errc[1], fall[0]);
        chk("t3_und", undc.size(), 1);
        chk("t3_und_at", undc[0], rise[0] + 20);
        chk("t3_gap", rise[1] - fall[0], 25);
        chk("t3_acc", acc.size(), 6);
        chk("t3_cnt", fcnt, 4);

        // stray bytes then a normal frame
        put(0, 3, 'h70, 1'b0);
        put(3, 4, 'h80, 1'b1);
        run(7, -1, 0, 80, 0);
        exp_frame(3, 4);
        chk("t4_acc", acc.size(), 7);
        chk("t4_stray0", acc[0], pres0 - 3);
        chk("t4_stray2", acc[2], pres0 - 1);
        chk("t4_rises", rise.size(), 1);
        chk("t4_lat", rise[0], pres0 + 1);
        chk("t4_nibs", nib_bad(), 0);
        chk("t4_cnt", fcnt, 5);

        // giga_mode holds a waiting SOP for 100 cycles
        put(0, 4, 'h90, 1'b1);
        run(4, -1, 0, 170, 100);
        exp_frame(0, 4);
        chk("t6_rise", rise[0], pres0 + 101);
        chk("t6_acc", acc.size(), 4);
        chk("t6_acc0", acc[0], pres0 + 116);
        chk("t6_nibs", nib_bad(), 0);
        chk("t6_cnt", fcnt, 6);

        // reset in the middle of a payload
        put(0, 10, 'h40, 1'b1);
        run(10, -1, 0, 20, 0);
        chk("t5_mid", ctrl, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        rst_n = 1'b0;
        #1;
        chk("t5_ctrl", ctrl, 0);
        chk("t5_err", err, 0);
        chk("t5_data", data, 0);
        chk("t5_ready", bus.in_ready, 0);
        chk("t5_cnt0", fcnt, 0);
        idle_bus();
        repeat (3) @(negedge rgmii_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge rgmii_clk);
        put(0, 9, 'h31, 1'b1);
        run(9, -1, 0, 80, 0);
        exp_123();
        chk("t5_len", nib.size(), ex.size());
        chk("t5_nibs", nib_bad(), 0);
        chk("t5_sop", sopc.size(), 1);
        chk("t5_cnt", fcnt, 1);

        #1;
        chk("end_ctrl", ctrl, 0);
        chk("end_data", data, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rgmii_tx_framer.md
Name: rgmii_tx_framer

Overview:
- 100M RGMII transmit framer; the transmit-side counterpart of the receive-side TSU sniffer.
- Accepts a byte stream with a valid/ready handshake and SOP/EOP markers, and emits RGMII nibbles on the single-edge 25 MHz model: preamble, SFD, payload, optional FCS, then the inter-frame gap.
- Emits a one-cycle start-of-payload strobe so a TX timestamp unit can capture RTC time at the SFD boundary.

Parameters:
PREAMBLE_BYTES, 7, number of 0x55 bytes sent before the SFD
IFG_BYTES, 12, inter-frame gap in bytes; the gap lasts 2*IFG_BYTES cycles

Ports:
rgmii_clk  in  1  25 MHz transmit clock; the only clock
rst_n  in  1  asynchronous, active-low reset
giga_mode  in  1  1 = 1000M mode (not supported: block held idle)
in_data  in  8  payload byte
in_valid  in  1  in_data is valid
in_sop  in  1  in_data is the first byte of a frame
in_eop  in  1  in_data is the last byte of a frame
in_ready  out  1  byte accepted when in_valid & in_ready
rgmii_tx_ctrl  out  1  TX_EN
rgmii_tx_err  out  1  TX_ER
rgmii_tx_data  out  4  transmit nibble, low nibble first
tx_sop  out  1  one-cycle pulse on the first payload nibble
tx_underrun  out  1  one-cycle pulse when a frame is aborted
frame_cnt  out  16  count of frames completed without abort; wraps at 0xFFFF->0

Behaviour:
- Reset: async on rst_n low. All outputs = 0, state = IDLE, byte register and CRC cleared. Reset asserted mid-frame truncates the frame immediately (tx_ctrl drops in the same reset event).
- Handshake rule: once in_valid rises, in_valid and in_data hold until accepted.
- Output encoding: one nibble per cycle; each byte is sent as [3:0] then [7:4].
- IDLE:
  - giga_mode=1: in_ready=0, outputs stay 0.
  - in_valid & !in_sop: in_ready=1 and the stray byte is discarded.
  - in_valid & in_sop: go to PREAMBLE without consuming the byte.
- PREAMBLE: 2*PREAMBLE_BYTES cycles, data=0x5, ctrl=1. The first ctrl=1 cycle is 1 cycle after in_valid&in_sop is seen in IDLE.
- SFD: 2 cycles, data 0x5 then 0xD.
  - in_ready=1 on the 0xD cycle; this consumes the SOP byte into the byte register.
  - CRC is initialised to 0xFFFFFFFF.
- PAYLOAD:
  - Each byte: low-nibble cycle, then high-nibble cycle.
  - tx_sop=1 on the first low-nibble cycle.
  - CRC is updated per byte (reflected CRC-32, poly 0x04C11DB7) as the byte is loaded.
  - On each high-nibble cycle, in_ready=1 unless the current byte is EOP.
  - Current byte is EOP: after its high nibble, go to FCS (or IFG when the feature is off); frame_cnt increments when the last nibble leaves.
  - in_ready=1 and in_valid=0 (underrun): the current high nibble completes, then go to ABORT.
- ABORT: 2 cycles, ctrl=1, err=1, data=0. tx_underrun pulses on the first ABORT cycle. frame_cnt is unchanged. Next state is IFG.
- FCS: 8 cycles, sending ~CRC least-significant byte first, low nibble first. in_ready=0.
- IFG: ctrl=0, data=0, for 2*IFG_BYTES cycles, then IDLE.
  - A new SOP waiting during IFG is not accepted early.
  - Back-to-back frames therefore start exactly 2*IFG_BYTES+1 cycles after the last data nibble.
- Idle outputs: rgmii_tx_err=0 except in ABORT; rgmii_tx_data=0 whenever ctrl=0.
- Wrap-around: the preamble, IFG and FCS counters are sized from the parameters and never wrap inside a state.

Optional Feature:
TX_FCS_EN
- Defined: CRC-32 is computed and the FCS state appends 4 bytes.
- Undefined: no CRC logic and no FCS state. Upstream supplies the FCS in the payload, and the state after the EOP byte is IFG.

Test Plan:
- Single frame, TX_FCS_EN defined: payload "123456789" (0x31..0x39) -> 7x0x55 nibble pairs, 0x5/0xD, payload nibbles 1,3,2,3..9,3, then FCS bytes 0x26 0x39 0xF4 0xCB (nibbles 6,2,9,3,4,F,B,C).
  - Also: tx_sop once, on the nibble 1 cycle.
  - Also: frame_cnt 0->1.
- Latency and IFG: two back-to-back 4-byte frames -> first ctrl=1 one cycle after SOP presented, 2nd frame ctrl rise exactly 25 cycles after the 1st frame's last nibble, in_ready pulses = 4 per frame.
- Underrun: drop in_valid before the 3rd byte of a 10-byte frame -> ctrl=1/err=1 for 2 cycles after byte 2, tx_underrun one pulse, frame_cnt unchanged, then 24 idle cycles.
- Stray bytes: 3 bytes without SOP while IDLE -> all accepted and discarded, ctrl stays 0; a subsequent SOP frame transmits normally.
- Reset mid-PAYLOAD: rst_n low -> ctrl/err/data/in_ready = 0 immediately; after release a new frame transmits cleanly with correct FCS.
- giga_mode=1 with SOP presented -> in_ready=0, ctrl=0 for 100 cycles; clear giga_mode -> frame starts next cycle.
